// File: rtl/stream_cipher_xor.sv
// stream_cipher_xor
//
// Purpose:
//   LFSR keystream cipher. Each accepted input word is XORed with the low
//   WIDTH bits of a 64-bit Galois LFSR, and the result is returned through
//   a one-deep registered valid/ready output stage. XOR is its own inverse,
//   so one block serves as both encryptor and decryptor. The keystream
//   advances only on accepted beats. As a result, two blocks that start
//   from the same seed stay in lock-step under any backpressure pattern.
//
// Parameters:
//   WIDTH  data word width (1..64); keystream = low WIDTH bits of the LFSR
//   TAPS   Galois feedback mask applied when the shifted-out bit is 1
//   SEED   reset state and replacement for an all-zero seed (nonzero)
//   CNT_W  width of the beat counter
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   seed_load  pulse: load seed_in into the LFSR on the next edge
//   seed_in    new 64-bit LFSR state (zero is replaced by SEED)
//   in_valid   input word present
//   in_ready   block can accept an input word this cycle
//   in_data    plaintext or ciphertext word
//   out_valid  out_data holds a result
//   out_ready  sink accepts out_data
//   out_data   in_data XOR keystream
//   beat_cnt   words accepted since reset or the last seed load (wraps)

module stream_cipher_xor #(
    parameter int          WIDTH = 64,
    parameter logic [63:0] TAPS  = 64'hD800_0000_0000_0000,
    parameter logic [63:0] SEED  = 64'h0000_0000_0000_0001,
    parameter int          CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [63:0]      seed_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] beat_cnt
);

    logic [63:0] s;
    logic [63:0] s_step;
    logic [63:0] seed_eff;
    logic        acc;

    // The output register is the only storage stage. A new word can enter
    // when the stage is empty, or when its current word leaves this cycle.
    assign in_ready = ~out_valid | out_ready;
    assign acc      = in_valid & in_ready;

    // One Galois step: shift right, fold the taps in when a 1 falls out.
    assign s_step = (s >> 1) ^ (s[0] ? TAPS : 64'd0);

    // An all-zero LFSR would lock up, so a zero seed falls back to SEED.
    assign seed_eff = (seed_in == 64'd0) ? SEED : seed_in;

    // LFSR state. A seed load takes priority over the step. The accepted
    // word of that cycle has already used the old state on the data path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= SEED;
        end else if (seed_load) begin
            s <= seed_eff;
        end else if (acc) begin
            s <= s_step;
        end
    end

    // Beat counter. A seed load restarts the count at zero, even when a
    // word is accepted in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (seed_load) begin
            beat_cnt <= '0;
        end else if (acc) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    // Output stage. out_data keeps its last value after the word is
    // consumed, and a seed load never disturbs a pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ s[WIDTH-1:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_cipher_xor.sv
// tb_stream_cipher_xor
//
// Purpose:
//   Self-checking bench for stream_cipher_xor. It covers reset values, the
//   known-answer keystream, backpressure, seed loading, a narrow WIDTH=8
//   variant, asynchronous reset mid-stream, a randomized stream compared
//   against a keystream-index model, and an encrypt/decrypt round trip
//   through two cascaded instances.
//
// Ports: none (top-level bench).

module tb_stream_cipher_xor;

    localparam logic [63:0] TAPS_C = 64'hD800_0000_0000_0000;
    localparam logic [63:0] SEED_C = 64'h0000_0000_0000_0001;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // main 64-bit instance
    logic        seed_load;
    logic [63:0] seed_in;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [31:0] beat_cnt;

    // WIDTH=8 instance
    logic        w8_seed_load;
    logic [63:0] w8_seed_in;
    logic        w8_in_valid;
    logic        w8_in_ready;
    logic [7:0]  w8_in_data;
    logic        w8_out_valid;
    logic        w8_out_ready;
    logic [7:0]  w8_out_data;
    logic [31:0] w8_beat_cnt;

    // round-trip pair: A encrypts, B decrypts
    logic        rt_seed_load;
    logic [63:0] rt_seed_in;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [63:0] a_in_data;
    logic        a_out_valid;
    logic [63:0] a_out_data;
    logic [31:0] a_beat_cnt;
    logic        b_in_ready;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [63:0] b_out_data;
    logic [31:0] b_beat_cnt;

    stream_cipher_xor dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .beat_cnt(beat_cnt)
    );

    stream_cipher_xor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .seed_load(w8_seed_load), .seed_in(w8_seed_in),
        .in_valid(w8_in_valid), .in_ready(w8_in_ready), .in_data(w8_in_data),
        .out_valid(w8_out_valid), .out_ready(w8_out_ready), .out_data(w8_out_data),
        .beat_cnt(w8_beat_cnt)
    );

    stream_cipher_xor rt_a (
        .clk(clk), .rst(rst), .seed_load(rt_seed_load), .seed_in(rt_seed_in),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(b_in_ready), .out_data(a_out_data),
        .beat_cnt(a_beat_cnt)
    );

    stream_cipher_xor rt_b (
        .clk(clk), .rst(rst), .seed_load(rt_seed_load), .seed_in(rt_seed_in),
        .in_valid(a_out_valid), .in_ready(b_in_ready), .in_data(a_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .beat_cnt(b_beat_cnt)
    );

    // Keystream word number n after starting from state st: apply the
    // Galois recurrence n times.
    function automatic logic [63:0] keystream(input logic [63:0] st, input int n);
        logic [63:0] v;
        v = st;
        for (int k = 0; k < n; k++) begin
            if (v % 2 == 1) v = (v / 2) ^ TAPS_C;
            else            v = v / 2;
        end
        return v;
    endfunction

    task automatic idle_inputs();
        seed_load = 1'b0; seed_in = 64'd0; in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b1;
        w8_seed_load = 1'b0; w8_seed_in = 64'd0; w8_in_valid = 1'b0; w8_in_data = 8'd0;
        w8_out_ready = 1'b1;
        rt_seed_load = 1'b0; rt_seed_in = 64'd0; a_in_valid = 1'b0; a_in_data = 64'd0;
        b_out_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++;
        if (out_data !== 64'd0) begin errors++; $display("[TB] FAIL reset_out_data got %h expected 0", out_data); end
        checks++;
        if (beat_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_beat_cnt got %0d expected 0", beat_cnt); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_known_answer();
        logic [63:0] din [3];
        logic [63:0] exp [3];
        din[0] = 64'd0; din[1] = 64'd0; din[2] = 64'd8388761;
        exp[0] = 64'h1; exp[1] = 64'hD800_0000_0000_0000;
        exp[2] = 64'd8388761 ^ 64'h6C00_0000_0000_0000;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = din[i];
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                errors++;
                $display("[TB] FAIL kat_word%0d got v=%b %h expected v=1 %h", i, out_valid, out_data, exp[i]);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (beat_cnt !== 32'd3) begin errors++; $display("[TB] FAIL kat_beat_cnt got %0d expected 3", beat_cnt); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL kat_drain got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1; in_data = 64'd0; out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 64'h1 || beat_cnt !== 32'd1) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d got rdy=%b v=%b d=%h cnt=%0d expected rdy=0 v=1 d=1 cnt=1",
                         i, in_ready, out_valid, out_data, beat_cnt);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_data !== 64'hD800_0000_0000_0000 || beat_cnt !== 32'd2) begin
            errors++;
            $display("[TB] FAIL bp_next_word got %h cnt=%0d expected d800000000000000 cnt=2", out_data, beat_cnt);
        end
    endtask

    task automatic test_seed_load();
        logic [63:0] exp;
        do_reset();
        // zero seed falls back to SEED
        seed_load = 1'b1; seed_in = 64'd0;
        @(negedge clk);
        seed_load = 1'b0; in_valid = 1'b1; in_data = 64'd0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_data !== 64'h1) begin errors++; $display("[TB] FAIL seed_zero got %h expected 1", out_data); end
        // explicit seed
        seed_load = 1'b1; seed_in = 64'hDEAD_BEEF;
        @(negedge clk);
        seed_load = 1'b0; in_valid = 1'b1; in_data = 64'd0;
        @(negedge clk);
        checks++;
        if (out_data !== 64'hDEAD_BEEF || beat_cnt !== 32'd1) begin
            errors++;
            $display("[TB] FAIL seed_deadbeef got %h cnt=%0d expected deadbeef cnt=1", out_data, beat_cnt);
        end
        // load coincident with an accepted word
        seed_load = 1'b1; seed_in = 64'h1234_5678_9ABC_DEF0; in_valid = 1'b1; in_data = 64'd0;
        exp = keystream(64'hDEAD_BEEF, 1);
        @(negedge clk);
        seed_load = 1'b0;
        checks++;
        if (out_data !== exp || beat_cnt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL seed_coincident got %h cnt=%0d expected %h cnt=0", out_data, beat_cnt, exp);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_data !== 64'h1234_5678_9ABC_DEF0 || beat_cnt !== 32'd1) begin
            errors++;
            $display("[TB] FAIL seed_after_coincident got %h cnt=%0d expected 123456789abcdef0 cnt=1",
                     out_data, beat_cnt);
        end
    endtask

    task automatic test_width8();
        logic [7:0] d;
        logic [7:0] exp;
        do_reset();
        for (int i = 0; i < 70; i++) begin
            d = (i < 2) ? 8'd0 : 8'($urandom);
            w8_in_valid = 1'b1; w8_in_data = d;
            exp = d ^ keystream(SEED_C, i);
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (w8_out_data !== 8'h01) begin errors++; $display("[TB] FAIL w8_first got %h expected 01", w8_out_data); end
            end else if (i == 1) begin
                checks++;
                if (w8_out_data !== 8'h00) begin errors++; $display("[TB] FAIL w8_second got %h expected 00", w8_out_data); end
            end
            checks++;
            if (w8_out_valid !== 1'b1 || w8_out_data !== exp) begin
                errors++;
                $display("[TB] FAIL w8_word%0d got v=%b %h expected v=1 %h", i, w8_out_valid, w8_out_data, exp);
            end
        end
        w8_in_valid = 1'b0;
        checks++;
        if (w8_beat_cnt !== 32'd70) begin errors++; $display("[TB] FAIL w8_beat_cnt got %0d expected 70", w8_beat_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid = 1'b1; in_data = 64'd0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL arst_pending got %b expected 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'd0 || beat_cnt !== 32'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL arst_no_edge got v=%b d=%h cnt=%0d rdy=%b expected v=0 d=0 cnt=0 rdy=1",
                     out_valid, out_data, beat_cnt, in_ready);
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 64'd0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_data !== SEED_C) begin errors++; $display("[TB] FAIL arst_restart got %h expected %h", out_data, SEED_C); end
    endtask

    task automatic test_random();
        logic [63:0] base;
        int          idx;
        logic        m_ov;
        logic [63:0] m_od;
        logic        exp_ready;
        do_reset();
        base = SEED_C; idx = 0; m_ov = 1'b0; m_od = 64'd0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== m_ov || out_data !== m_od || beat_cnt !== 32'(idx)) begin
                errors++;
                $display("[TB] FAIL rand_state%0d got v=%b d=%h cnt=%0d expected v=%b d=%h cnt=%0d",
                         c, out_valid, out_data, beat_cnt, m_ov, m_od, idx);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            seed_load = ($urandom_range(0, 19) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            #1;
            exp_ready = !m_ov || out_ready;
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL rand_ready%0d got %b expected %b", c, in_ready, exp_ready);
            end
            if (in_valid && exp_ready) begin
                m_od = in_data ^ keystream(base, idx);
                m_ov = 1'b1;
                idx++;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (seed_load) begin
                base = (seed_in == 64'd0) ? SEED_C : seed_in;
                idx  = 0;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_round_trip();
        logic [63:0] sent [$];
        logic [63:0] a_word;
        logic [63:0] exp;
        int          tx;
        int          rx;
        int          cyc;
        do_reset();
        tx = 0; rx = 0; cyc = 0;
        a_word = {$urandom, $urandom};
        while (rx < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            a_in_valid  = (tx < 1000) && ($urandom_range(0, 3) != 0);
            a_in_data   = a_word;
            b_out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (a_in_valid && a_in_ready) begin
                sent.push_back(a_word);
                tx++;
                a_word = {$urandom, $urandom};
            end
            if (b_out_valid && b_out_ready) begin
                exp = (sent.size() > 0) ? sent.pop_front() : ~b_out_data;
                checks++;
                if (b_out_data !== exp) begin
                    errors++;
                    $display("[TB] FAIL rt_word%0d got %h expected %h", rx, b_out_data, exp);
                end
                rx++;
            end
        end
        checks++;
        if (rx != 1000) begin errors++; $display("[TB] FAIL rt_timeout got %0d words expected 1000", rx); end
        @(negedge clk);
        a_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (a_beat_cnt !== 32'd1000 || b_beat_cnt !== 32'd1000) begin
            errors++;
            $display("[TB] FAIL rt_beat_cnt got a=%0d b=%0d expected 1000 1000", a_beat_cnt, b_beat_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_known_answer();
        test_backpressure();
        test_seed_load();
        test_width8();
        test_async_reset();
        test_random();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_cipher_xor.md
# stream_cipher_xor

Parametrised LFSR keystream cipher. It XORs each accepted input word with the current keystream word and returns the result through a registered valid/ready output stage. The XOR is symmetric, so the same block serves as encryptor and decryptor. It is the successor to the free-running 64-bit decryption unit, and adds three things that unit lacks:
- width and polynomial parameters;
- runtime seed loading;
- flow control, so the keystream advances only on accepted beats and both ends stay in sync under backpressure.

## Interface
Parameters:
- WIDTH, 64: data word width, 1..64; keystream word = low WIDTH bits of LFSR state.
- TAPS, 64'hD800_0000_0000_0000: Galois feedback mask (x^64+x^63+x^61+x^60+1).
- SEED, 64'h0000_0000_0000_0001: reset state and substitute for an all-zero seed; must be nonzero.
- CNT_W, 32: width of the beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- seed_load  in  1  pulse; loads seed_in into LFSR on next edge.
- seed_in  in  64  new LFSR state.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept input this cycle.
- in_data  in  WIDTH  plaintext or ciphertext word.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  sink accepts out_data.
- out_data  out  WIDTH  in_data XOR keystream.
- beat_cnt  out  CNT_W  words accepted since reset/seed load.

## Operation
- State: 64-bit LFSR register `s`, output register (out_valid, out_data), beat counter.
- Accept: `acc = in_valid & in_ready`, where `in_ready = ~out_valid | out_ready` (combinational, one-deep pipeline, no skid).
- On acc:
  - out_data <= in_data ^ s[WIDTH-1:0], using the pre-advance `s`;
  - out_valid <= 1;
  - s advances one Galois step: `s_next = (s >> 1) ^ (s[0] ? TAPS : 0)`;
  - beat_cnt increments.
- If out_valid & out_ready & ~acc: out_valid <= 0. out_data holds its last value.
- No acc: s, beat_cnt and out_data are unchanged. Backpressure never consumes keystream.
- seed_load:
  - s <= (seed_in == 0) ? SEED : seed_in;
  - beat_cnt <= 0.
- seed_load together with acc in the same cycle:
  - the accepted word uses the old `s`;
  - the load wins over the step, so `s` = loaded seed;
  - beat_cnt = 0, not 1.
- seed_load does not disturb a pending output word. out_valid and out_data keep their values.
- beat_cnt wraps from 2^CNT_W-1 to 0. No flag is raised.
- All-zero state is unreachable: reset uses a nonzero SEED and zero seeds are substituted.

## Timing
- Reset (async assert, synchronous-release path is the integrator's concern):
  - s = SEED;
  - out_valid = 0;
  - out_data = 0;
  - beat_cnt = 0;
  - in_ready = 1 immediately.
- Latency: one cycle from an accepted input to out_valid.
- Throughput: one word per cycle while out_ready is held high.
- in_ready falls in the same cycle that out_valid=1 and out_ready=0.
- out_data is stable while out_valid=1 and out_ready=0.
- Reset asserted mid-stream:
  - the pending output is dropped (out_valid=0);
  - the keystream restarts from SEED;
  - the beat after release uses keystream = SEED[WIDTH-1:0].
- seed_load takes effect for the first word accepted on a later edge. It has no effect on a word accepted in the load cycle.

## Test plan
- After reset, defaults, WIDTH=64, out_ready=1: send in_data 0, 0, 64'd8388761 back to back -> out_data 64'h1, 64'hD800_0000_0000_0000, 64'd8388761 ^ 64'h6C00_0000_0000_0000 on consecutive cycles; beat_cnt=3.
- Round trip: two instances, same SEED, cascaded (out of A into in of B), random 1000-word stream with random in_valid/out_ready -> B out_data equals A input sequence exactly; both beat_cnt equal.
- Backpressure: out_ready=0 for 5 cycles after one word -> in_ready=0, out_data stable, beat_cnt=1. After out_ready=1, next word uses keystream 64'hD800_0000_0000_0000.
- seed_load with seed_in=0 -> next word (in_data 0) outputs 64'h1. seed_load with seed_in=64'hDEAD_BEEF -> next zero word outputs 64'hDEAD_BEEF. Load coincident with acc -> coincident word uses old keystream; beat_cnt=0 afterwards.
- WIDTH=8: zero input words -> out_data 8'h01, 8'h00; state still advances per beat as in the 64-bit case.
- Reset asserted while out_valid=1 -> out_valid=0 and out_data=0 without a clock edge. The first post-release zero word outputs SEED[WIDTH-1:0].
